dbus_arbiter: RTL
=================

Name: dbus_arbiter

Overview:
- Two-master AHB-lite data-bus arbiter in front of the single data-bus port.
- M0 is the core LSU. M1 is an auxiliary master (memory scrubber / debug access).
- Handles address-phase grant with fixed M0 priority, M1 starvation escape, and an M0 lock that keeps read-modify-write sequences atomic.
- Tracks the data-phase owner to route hwdata, hready, hresp and check bits.

Parameters:
- MAX_WAIT, 8: cycles M1 may be refused (with slave hready high) before it wins over an unlocked M0.
- CNT_W, $clog2(MAX_WAIT+1): width of the starvation counter.

Ports:
- s_clk_i  in  1  clock
- s_reset_i  in  1  reset; synchronous, active-high
- s_mX_haddr_i  in  32  master X address (X = 0,1 for every s_mX port)
- s_mX_htrans_i  in  2  master X transfer type
- s_mX_hsize_i  in  3  master X size
- s_mX_hwrite_i  in  1  master X write
- s_mX_hparity_i  in  6  master X address/control parity
- s_mX_hwdata_i  in  32  master X write data
- s_mX_hwdcheck_i  in  7  master X write-data checksum
- s_mX_hready_o  out  1  ready returned to master X
- s_mX_hresp_o  out  1  error response returned to master X
- s_m0_lock_i  in  1  LSU RMW in progress; M1 must not be granted
- s_haddr_o  out  32  slave address
- s_htrans_o  out  2  slave transfer type
- s_hsize_o  out  3  slave size
- s_hwrite_o  out  1  slave write
- s_hparity_o  out  6  slave parity
- s_hwdata_o  out  32  slave write data
- s_hwdcheck_o  out  7  slave write-data checksum
- s_hready_i  in  1  slave ready
- s_hresp_i  in  1  slave error response
- s_hrdata_o  out  32  read data, broadcast unmodified to both masters
- s_hrdcheck_o  out  7  read checksum, broadcast unmodified
- s_hrdata_i  in  32  slave read data
- s_hrdcheck_i  in  7  slave read checksum
- s_grant_o  out  1  current address-phase grant (0 = M0, 1 = M1)

Behaviour:
- reqX = s_mX_htrans_i[1].
- Registers: grant_q, dp_valid_q, dp_owner_q, wait_q. On reset all are 0, so grant parks on M0 with no data phase outstanding.
- Grant (combinational):
  - s_hready_i = 0: grant = grant_q. The address phase is frozen.
  - Otherwise, in priority order:
    1. s_m0_lock_i → M0
    2. req1 && wait_q == MAX_WAIT → M1
    3. req0 → M0
    4. req1 → M1
    5. otherwise → M0 (park)
- grant_q <= grant every cycle.
- Address mux: haddr, hsize, hwrite and hparity come from the granted master. s_htrans_o = granted htrans.
- While s_reset_i is high: s_htrans_o = IDLE and s_hparity_o[5] = 0. All other parity bits pass through.
- Data-phase tracking, when s_hready_i = 1: dp_valid_q <= s_htrans_o[1]; dp_owner_q <= grant. Otherwise both hold.
- Data mux: s_hwdata_o and s_hwdcheck_o are selected by dp_owner_q (M0 when !dp_valid_q).
- hready to master X:
  - = s_hready_i if (dp_valid_q && dp_owner_q == X) or (grant == X).
  - = 0 if reqX with grant != X. The master is held and keeps its address stable.
  - = 1 otherwise (idle master with no outstanding data phase).
- hresp to master X: s_hresp_i && dp_valid_q && dp_owner_q == X. Both hresp cycles go only to the owner.
- Starvation counter:
  - On s_hready_i && grant == M1: wait_q <= 0.
  - On s_hready_i && req1 && grant == M0 && !s_m0_lock_i: wait_q <= wait_q + 1, saturating at MAX_WAIT.
  - Otherwise hold.
  - Lock cycles do not count toward starvation.
- Lock rising while M1 is in its data phase: M1 completes normally. M0's next address is granted because lock forces M0.
- Simultaneous requests with wait_q < MAX_WAIT: M0 wins and wait_q increments.
- Reset mid-transfer: all registers clear next edge and htrans is forced IDLE during reset. Slave-side completion of an in-flight transfer is not tracked across reset.
- Latency: zero added cycles. The grant switch happens in the same cycle as slave hready.

Decomposition:
- p_hardisc gains:
  - typedef dbus_master_t, 1-bit, with constants DBUS_M0 / DBUS_M1.
  - parameter DBUS_MAX_WAIT default.
  - constants HTRANS_IDLE = 2'b00 and HTRANS_NONSEQ = 2'b10.
- No sub-module. The starvation counter is inline; the mux logic is too thin to split.

Test Plan:
- Only M0 issues NONSEQ loads at 0x100, 0x104 with s_hready_i = 1 → grant stays 0; s_m0_hready_o = 1; s_m1_hready_o = 1; hresp stays 0.
- M0 and M1 request continuously, MAX_WAIT = 8, no lock → M0 granted 8 cycles; M1 granted in cycle 9; wait_q returns to 0.
- s_m0_lock_i held 20 cycles with M1 requesting → M1 never granted; s_m1_hready_o = 0 throughout; wait_q unchanged.
- M1 write 0xDEADBEEF to 0x200, then M0 address in the next cycle → s_hwdata_o = 0xDEADBEEF during M1's data phase while s_haddr_o carries M0's address.
- Slave returns two-cycle error (hready 0/1, hresp 1/1) for an M1 transfer → s_m1_hresp_o = 1 both cycles; s_m0_hresp_o = 0.
- s_hready_i low 3 cycles during an M0 address phase while M1 raises a request → grant frozen at 0; s_haddr_o stable; reset asserted next cycle → s_htrans_o = 00 and grant = 0.

Source files
------------

// File: rtl/dbus_arbiter_pkg.sv
// Shared types and constants for the two-master data-bus arbiter.
package dbus_arbiter_pkg;

  typedef enum logic {
    DBUS_M0 = 1'b0,
    DBUS_M1 = 1'b1
  } dbus_master_t;

  localparam int DBUS_MAX_WAIT = 8;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

endpackage

// File: rtl/dbus_arbiter.sv
// AHB-lite arbiter for the LSU (M0) and an auxiliary master (M1) sharing one
// data-bus port: fixed M0 priority, M1 starvation escape, M0 RMW lock.
module dbus_arbiter
  import dbus_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = DBUS_MAX_WAIT,
  parameter int CNT_W    = $clog2(MAX_WAIT + 1)
) (
  input  logic        s_clk_i,
  input  logic        s_reset_i,
  input  logic [31:0] s_m0_haddr_i,
  input  logic [1:0]  s_m0_htrans_i,
  input  logic [2:0]  s_m0_hsize_i,
  input  logic        s_m0_hwrite_i,
  input  logic [5:0]  s_m0_hparity_i,
  input  logic [31:0] s_m0_hwdata_i,
  input  logic [6:0]  s_m0_hwdcheck_i,
  output logic        s_m0_hready_o,
  output logic        s_m0_hresp_o,
  input  logic        s_m0_lock_i,
  input  logic [31:0] s_m1_haddr_i,
  input  logic [1:0]  s_m1_htrans_i,
  input  logic [2:0]  s_m1_hsize_i,
  input  logic        s_m1_hwrite_i,
  input  logic [5:0]  s_m1_hparity_i,
  input  logic [31:0] s_m1_hwdata_i,
  input  logic [6:0]  s_m1_hwdcheck_i,
  output logic        s_m1_hready_o,
  output logic        s_m1_hresp_o,
  output logic [31:0] s_haddr_o,
  output logic [1:0]  s_htrans_o,
  output logic [2:0]  s_hsize_o,
  output logic        s_hwrite_o,
  output logic [5:0]  s_hparity_o,
  output logic [31:0] s_hwdata_o,
  output logic [6:0]  s_hwdcheck_o,
  input  logic        s_hready_i,
  input  logic        s_hresp_i,
  output logic [31:0] s_hrdata_o,
  output logic [6:0]  s_hrdcheck_o,
  input  logic [31:0] s_hrdata_i,
  input  logic [6:0]  s_hrdcheck_i,
  output logic        s_grant_o
);

  dbus_master_t grant_q;
  dbus_master_t grant;
  dbus_master_t dp_owner_q;
  dbus_master_t dp_src;
  logic         dp_valid_q;
  logic [CNT_W-1:0] wait_q;

  logic [1:0] req;
  logic [1:0] hready_m;
  logic [1:0] hresp_m;
  logic [1:0] granted_htrans;
  logic [5:0] granted_parity;
  logic       starved;

  assign req     = {s_m1_htrans_i[1], s_m0_htrans_i[1]};
  assign starved = (wait_q == CNT_W'(MAX_WAIT));

  always_comb begin
    grant = DBUS_M0;
    if (!s_hready_i)                grant = grant_q;
    else if (s_m0_lock_i)           grant = DBUS_M0;
    else if (req[1] && starved)     grant = DBUS_M1;
    else if (req[0])                grant = DBUS_M0;
    else if (req[1])                grant = DBUS_M1;
  end

  // Address phase follows the current grant with no added latency.
  assign granted_htrans = (grant == DBUS_M1) ? s_m1_htrans_i  : s_m0_htrans_i;
  assign granted_parity = (grant == DBUS_M1) ? s_m1_hparity_i : s_m0_hparity_i;
  assign s_haddr_o   = (grant == DBUS_M1) ? s_m1_haddr_i  : s_m0_haddr_i;
  assign s_hsize_o   = (grant == DBUS_M1) ? s_m1_hsize_i  : s_m0_hsize_i;
  assign s_hwrite_o  = (grant == DBUS_M1) ? s_m1_hwrite_i : s_m0_hwrite_i;
  assign s_htrans_o  = s_reset_i ? HTRANS_IDLE : granted_htrans;
  assign s_hparity_o = {granted_parity[5] & ~s_reset_i, granted_parity[4:0]};
  assign s_grant_o   = grant;

  assign dp_src       = dp_valid_q ? dp_owner_q : DBUS_M0;
  assign s_hwdata_o   = (dp_src == DBUS_M1) ? s_m1_hwdata_i   : s_m0_hwdata_i;
  assign s_hwdcheck_o = (dp_src == DBUS_M1) ? s_m1_hwdcheck_i : s_m0_hwdcheck_i;
  assign s_hrdata_o   = s_hrdata_i;
  assign s_hrdcheck_o = s_hrdcheck_i;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_master
      localparam dbus_master_t ME = (gi == 0) ? DBUS_M0 : DBUS_M1;
      logic owns_dp;
      assign owns_dp = dp_valid_q && (dp_owner_q == ME);
      // A refused requester is stalled; an idle, uninvolved master sees ready.
      assign hready_m[gi] = (owns_dp || grant == ME) ? s_hready_i : ~req[gi];
      assign hresp_m[gi]  = s_hresp_i && owns_dp;
    end
  endgenerate

  assign s_m0_hready_o = hready_m[0];
  assign s_m1_hready_o = hready_m[1];
  assign s_m0_hresp_o  = hresp_m[0];
  assign s_m1_hresp_o  = hresp_m[1];

  always_ff @(posedge s_clk_i) begin
    if (s_reset_i) begin
      grant_q    <= DBUS_M0;
      dp_valid_q <= 1'b0;
      dp_owner_q <= DBUS_M0;
      wait_q     <= '0;
    end else begin
      grant_q <= grant;
      if (s_hready_i) begin
        dp_valid_q <= s_htrans_o[1];
        dp_owner_q <= grant;
        // Lock cycles never count toward M1 starvation.
        if (grant == DBUS_M1)
          wait_q <= '0;
        else if (req[1] && !s_m0_lock_i && !starved)
          wait_q <= wait_q + CNT_W'(1);
      end
    end
  end

endmodule
